// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM march BIST engine.
//   bist_state_e : controller states
//   PAT_DEFAULT  : default data background (its complement is the second one)
//   ERR_W/ERR_MAX: width and saturation value of the mismatch counter
//   DRAIN_W      : width of the drain down-counter (READ_LAT is at most 4)
package ram_bist_pkg;

  typedef enum logic [3:0] {
    IDLE,
    M0_W,
    M1_R,
    M1_W,
    M2_R,
    M2_W,
    M3_R,
    DRAIN,
    FIN
  } bist_state_e;

  localparam logic [7:0] PAT_DEFAULT = 8'h55;
  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam int DRAIN_W = 3;

endpackage

// File: rtl/bist_cmp_pipe.sv
// Read-compare pipeline for the march BIST.
// Each read cycle pushes {valid, addr, expected} into a READ_LAT-deep delay
// line. When an entry reaches the last stage the RAM's Q belongs to it and is
// compared against the expected value.
// Ports:
//   CLK, RST_N        clock, async active-low reset
//   clr               clears counter, first-fail capture and the delay line
//   push_vld          current cycle is a read cycle
//   push_addr/exp     address and expected data of that read
//   q                 RAM read data
//   err_cnt           saturating mismatch count
//   fail_addr/data    address and Q value of the first mismatch
module bist_cmp_pipe
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr,
  input  logic              push_vld,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_exp,
  input  logic [DATA_W-1:0] q,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic [READ_LAT-1:0]             vld_sr;
  logic [READ_LAT-1:0][ADDR_W-1:0] addr_sr;
  logic [READ_LAT-1:0][DATA_W-1:0] exp_sr;
  logic                            mismatch;

  assign mismatch = vld_sr[READ_LAT-1] && (q != exp_sr[READ_LAT-1]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_sr  <= '0;
      addr_sr <= '0;
      exp_sr  <= '0;
    end else begin
      if (clr) begin
        vld_sr <= '0;
      end else begin
        vld_sr[0] <= push_vld;
        for (int i = 1; i < READ_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      end
      addr_sr[0] <= push_addr;
      exp_sr[0]  <= push_exp;
      for (int i = 1; i < READ_LAT; i++) begin
        addr_sr[i] <= addr_sr[i-1];
        exp_sr[i]  <= exp_sr[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clr) begin
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch) begin
      // capture only the first failure of a run
      if (err_cnt == '0) begin
        fail_addr <= addr_sr[READ_LAT-1];
        fail_data <= q;
      end
      if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST controller (W, RW, RW, R with background PAT and ~PAT) driving
// one RAM port. Holds the FSM and address/data generation; read compares are
// done in bist_cmp_pipe.
// Ports:
//   CLK, RST_N   clock, async active-low reset
//   START        one-cycle run request (accepted in IDLE or FIN)
//   Q            RAM read data
//   WEN, A, D    RAM write enable, address, write data
//   BUSY, DONE   run in progress / run finished (sticky)
//   PASS         DONE with no mismatches
//   ERR_CNT      saturating mismatch count
//   FAIL_ADDR/FAIL_DATA  first mismatch address and read data
//
// state | meaning
// IDLE  | waiting for START after reset
// M0_W  | ascending, write PAT
// M1_R  | ascending, read expecting PAT
// M1_W  | ascending, write ~PAT
// M2_R  | descending, read expecting ~PAT
// M2_W  | descending, write PAT
// M3_R  | descending, read expecting PAT
// DRAIN | READ_LAT cycles for outstanding compares
// FIN   | results valid, waiting for START
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 1,
  parameter logic [DATA_W-1:0] PAT = PAT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] Q,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ERR_W-1:0]  ERR_CNT,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_DATA
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(READ_LAT - 1);

  bist_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DRAIN_W-1:0]  drn_q, drn_d;
  logic                clr;
  logic                push_vld;
  logic [DATA_W-1:0]   push_exp;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    drn_d    = drn_q;
    clr      = 1'b0;
    WEN      = 1'b0;
    A        = addr_q;
    D        = '0;
    BUSY     = 1'b1;
    push_vld = 1'b0;
    push_exp = '0;
    case (state_q)
      IDLE, FIN: begin
        A    = '0;
        BUSY = 1'b0;
        if (START) begin
          state_d = M0_W;
          addr_d  = '0;
          clr     = 1'b1;
        end
      end
      M0_W: begin
        WEN = 1'b1;
        D   = PAT;
        if (addr_q == LAST_ADDR) begin
          state_d = M1_R;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      M1_R: begin
        push_vld = 1'b1;
        push_exp = PAT;
        state_d  = M1_W;
      end
      M1_W: begin
        WEN = 1'b1;
        D   = ~PAT;
        if (addr_q == LAST_ADDR) begin
          state_d = M2_R;
          addr_d  = LAST_ADDR;
        end else begin
          state_d = M1_R;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      M2_R: begin
        push_vld = 1'b1;
        push_exp = ~PAT;
        state_d  = M2_W;
      end
      M2_W: begin
        WEN = 1'b1;
        D   = PAT;
        if (addr_q == '0) begin
          state_d = M3_R;
          addr_d  = LAST_ADDR;
        end else begin
          state_d = M2_R;
          addr_d  = addr_q - ADDR_W'(1);
        end
      end
      M3_R: begin
        push_vld = 1'b1;
        push_exp = PAT;
        if (addr_q == '0) begin
          state_d = DRAIN;
          drn_d   = DRAIN_LOAD;
        end else begin
          addr_d = addr_q - ADDR_W'(1);
        end
      end
      DRAIN: begin
        // A stays on the last read address while compares finish
        if (drn_q == '0) begin
          state_d = FIN;
          addr_d  = '0;
        end else begin
          drn_d = drn_q - DRAIN_W'(1);
        end
      end
      default: begin
        A       = '0;
        BUSY    = 1'b0;
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  assign DONE = (state_q == FIN);
  assign PASS = DONE && (ERR_CNT == '0);

  bist_cmp_pipe #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_cmp (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (clr),
    .push_vld (push_vld),
    .push_addr(addr_q),
    .push_exp (push_exp),
    .q        (Q),
    .err_cnt  (ERR_CNT),
    .fail_addr(FAIL_ADDR),
    .fail_data(FAIL_DATA)
  );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

  localparam int DEPTH = 32;
  localparam int NOPS  = 6 * DEPTH;
  localparam logic [7:0] PAT = 8'h55;

  logic CLK = 1'b0;
  logic RST_N, START, START2;

  logic       wen1, busy1, done1, pass1;
  logic [4:0] a1, faddr1;
  logic [7:0] d1, q1, err1, fdata1;
  logic       wen2, busy2, done2, pass2;
  logic [4:0] a2, faddr2;
  logic [7:0] d2, q2, r2a, err2, fdata2;

  always #5 CLK = ~CLK;

  ram_bist_ctrl #(.READ_LAT(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .Q(q1),
    .WEN(wen1), .A(a1), .D(d1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1), .FAIL_ADDR(faddr1), .FAIL_DATA(fdata1)
  );

  ram_bist_ctrl #(.READ_LAT(2)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .START(START2), .Q(q2),
    .WEN(wen2), .A(a2), .D(d2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(err2), .FAIL_ADDR(faddr2), .FAIL_DATA(fdata2)
  );

  // fault selection for the RAM beside u_dut: 0 none, 1 stuck bit, 2 A[4] ignored
  int         fkind = 0;
  logic [4:0] fa = '0;
  int         fb = 0;
  logic       fv = 1'b0;

  function automatic logic [4:0] map_a(input logic [4:0] a);
    return (fkind == 2) ? {1'b0, a[3:0]} : a;
  endfunction

  function automatic logic [7:0] store_d(input logic [4:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (fkind == 1 && a == fa) r[fb] = fv;
    return r;
  endfunction

  logic [7:0] mem1[DEPTH];
  logic [7:0] mem2[DEPTH];

  always @(posedge CLK) begin
    q1 <= mem1[map_a(a1)];
    if (wen1) mem1[map_a(a1)] <= store_d(a1, d1);
  end

  always @(posedge CLK) begin
    r2a <= mem2[a2];
    q2  <= r2a;
    if (wen2) mem2[a2] <= d2;
  end

  // reference march: expected bus per cycle after the START edge
  logic       op_we[NOPS];
  logic [4:0] op_a[NOPS];
  logic [7:0] op_d[NOPS];
  logic [7:0] op_exp[NOPS];

  int n_cmp = 0;
  int n_err = 0;

  int         run_cycles;
  logic       c1_done, c1_busy;
  logic [7:0] c1_err;
  logic       tr_wen[NOPS];
  logic [4:0] tr_a[NOPS];
  logic [7:0] tr_d[NOPS];

  task automatic build_ops();
    int k;
    k = 0;
    for (int a = 0; a < DEPTH; a++) begin
      op_we[k] = 1; op_a[k] = 5'(a); op_d[k] = PAT; op_exp[k] = '0; k++;
    end
    for (int a = 0; a < DEPTH; a++) begin
      op_we[k] = 0; op_a[k] = 5'(a); op_d[k] = '0; op_exp[k] = PAT; k++;
      op_we[k] = 1; op_a[k] = 5'(a); op_d[k] = ~PAT; op_exp[k] = '0; k++;
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      op_we[k] = 0; op_a[k] = 5'(a); op_d[k] = '0; op_exp[k] = ~PAT; k++;
      op_we[k] = 1; op_a[k] = 5'(a); op_d[k] = PAT; op_exp[k] = '0; k++;
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      op_we[k] = 0; op_a[k] = 5'(a); op_d[k] = '0; op_exp[k] = PAT; k++;
    end
  endtask

  // replays the march on an abstract faulty memory
  task automatic predict(output int e, output logic [4:0] pa, output logic [7:0] pd);
    logic [7:0] m[DEPTH];
    logic [7:0] got;
    e = 0; pa = '0; pd = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (op_we[i]) begin
        m[map_a(op_a[i])] = store_d(op_a[i], op_d[i]);
      end else begin
        got = m[map_a(op_a[i])];
        if (got !== op_exp[i]) begin
          if (e == 0) begin pa = op_a[i]; pd = got; end
          if (e < 255) e++;
        end
      end
    end
  endtask

  // pulses START, records the bus each cycle until DONE (bounded)
  task automatic run_march(input int repulse_at);
    int n;
    for (int i = 0; i < NOPS; i++) begin tr_wen[i] = 1'bx; tr_a[i] = 'x; tr_d[i] = 'x; end
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    n = 1;
    c1_done = done1; c1_busy = busy1; c1_err = err1;
    forever begin
      if (done1 === 1'b1) break;
      if (n <= NOPS) begin tr_wen[n-1] = wen1; tr_a[n-1] = a1; tr_d[n-1] = d1; end
      START = (n == repulse_at);
      if (n >= 400) break;
      @(negedge CLK); n++;
    end
    START = 1'b0;
    run_cycles = n;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b1; START2 = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      n_cmp++;
      if (wen1 !== 1'b0 || a1 !== '0 || d1 !== '0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
          pass1 !== 1'b0 || err1 !== '0 || faddr1 !== '0 || fdata1 !== '0) begin
        n_err++;
        $display("FAIL reset_dut1: wen=%b a=%0d d=%h busy=%b done=%b pass=%b err=%0d fa=%0d fd=%h, required all 0",
                 wen1, a1, d1, busy1, done1, pass1, err1, faddr1, fdata1);
      end
      n_cmp++;
      if (wen2 !== 1'b0 || a2 !== '0 || busy2 !== 1'b0 || done2 !== 1'b0 || err2 !== '0) begin
        n_err++;
        $display("FAIL reset_dut2: wen=%b a=%0d busy=%b done=%b err=%0d, required all 0",
                 wen2, a2, busy2, done2, err2);
      end
    end
    START = 1'b0; START2 = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy1, done1);
    end
  endtask

  task automatic test_clean_run();
    int nwr, nrd;
    logic [4:0] pa; logic [7:0] pd; int pe;
    fkind = 0;
    predict(pe, pa, pd);
    run_march(0);
    n_cmp++;
    if (run_cycles != 194) begin n_err++; $display("FAIL clean_latency: got %0d cycles, required 194", run_cycles); end
    n_cmp++;
    if (c1_busy !== 1'b1 || c1_done !== 1'b0) begin
      n_err++; $display("FAIL clean_first_cycle: busy=%b done=%b, required 1 0", c1_busy, c1_done);
    end
    nwr = 0; nrd = 0;
    for (int i = 0; i < NOPS; i++) begin
      if (tr_wen[i] === 1'b1) nwr++;
      if (tr_wen[i] === 1'b0) nrd++;
      n_cmp++;
      if (tr_wen[i] !== op_we[i] || tr_a[i] !== op_a[i] || tr_d[i] !== op_d[i]) begin
        n_err++;
        $display("FAIL clean_bus[%0d]: wen=%b a=%0d d=%h, required wen=%b a=%0d d=%h",
                 i, tr_wen[i], tr_a[i], tr_d[i], op_we[i], op_a[i], op_d[i]);
      end
    end
    n_cmp++;
    if (nwr != 96 || nrd != 96) begin n_err++; $display("FAIL clean_rw_count: wr=%0d rd=%0d, required 96 96", nwr, nrd); end
    n_cmp++;
    if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 8'(pe) || faddr1 !== pa || fdata1 !== pd) begin
      n_err++;
      $display("FAIL clean_result: done=%b pass=%b err=%0d fa=%0d fd=%h, required 1 1 %0d %0d %h",
               done1, pass1, err1, faddr1, fdata1, pe, pa, pd);
    end
    n_cmp++;
    if (busy1 !== 1'b0 || wen1 !== 1'b0 || a1 !== '0 || d1 !== '0) begin
      n_err++; $display("FAIL fin_outputs: busy=%b wen=%b a=%0d d=%h, required 0 0 0 00", busy1, wen1, a1, d1);
    end
  endtask

  task automatic test_stuck_at();
    fkind = 1; fa = 5'd5; fb = 0; fv = 1'b1;
    run_march(0);
    n_cmp++;
    if (run_cycles != 194) begin n_err++; $display("FAIL stuck_latency: got %0d, required 194", run_cycles); end
    n_cmp++;
    if (err1 !== 8'd1 || faddr1 !== 5'd5 || fdata1 !== 8'hAB || pass1 !== 1'b0 || done1 !== 1'b1) begin
      n_err++;
      $display("FAIL stuck_result: err=%0d fa=%0d fd=%h pass=%b done=%b, required 1 5 ab 0 1",
               err1, faddr1, fdata1, pass1, done1);
    end
    fkind = 0;
  endtask

  task automatic test_alias();
    fkind = 2;
    run_march(0);
    n_cmp++;
    if (c1_err !== 8'd0 || c1_done !== 1'b0) begin
      n_err++; $display("FAIL alias_start_clears: err=%0d done=%b, required 0 0", c1_err, c1_done);
    end
    n_cmp++;
    if (err1 !== 8'd32 || faddr1 !== 5'd16 || fdata1 !== 8'hAA || pass1 !== 1'b0) begin
      n_err++;
      $display("FAIL alias_result: err=%0d fa=%0d fd=%h pass=%b, required 32 16 aa 0", err1, faddr1, fdata1, pass1);
    end
    fkind = 0;
  endtask

  task automatic test_repulse();
    fkind = 0;
    run_march(20);
    n_cmp++;
    if (run_cycles != 194 || pass1 !== 1'b1 || err1 !== '0) begin
      n_err++; $display("FAIL repulse: cycles=%0d pass=%b err=%0d, required 194 1 0", run_cycles, pass1, err1);
    end
  endtask

  task automatic test_reset_abort();
    fkind = 0;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (49) @(negedge CLK);
    n_cmp++;
    if (wen1 !== op_we[49] || a1 !== op_a[49]) begin
      n_err++; $display("FAIL abort_pre: wen=%b a=%0d, required %b %0d", wen1, a1, op_we[49], op_a[49]);
    end
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (wen1 !== 1'b0 || busy1 !== 1'b0 || a1 !== '0 || done1 !== 1'b0 || err1 !== '0) begin
      n_err++;
      $display("FAIL abort_now: wen=%b busy=%b a=%0d done=%b err=%0d, required all 0", wen1, busy1, a1, done1, err1);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      n_cmp++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        n_err++; $display("FAIL abort_idle: done=%b busy=%b, required 0 0", done1, busy1);
      end
    end
    run_march(0);
    n_cmp++;
    if (run_cycles != 194 || pass1 !== 1'b1 || err1 !== '0) begin
      n_err++; $display("FAIL abort_restart: cycles=%0d pass=%b err=%0d, required 194 1 0", run_cycles, pass1, err1);
    end
  endtask

  task automatic test_read_lat2();
    int n;
    @(negedge CLK); START2 = 1'b1;
    @(negedge CLK); START2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
    n_cmp++;
    if (n != 195) begin n_err++; $display("FAIL lat2_latency: got %0d cycles, required 195", n); end
    n_cmp++;
    if (pass2 !== 1'b1 || err2 !== '0 || faddr2 !== '0 || fdata2 !== '0 || busy2 !== 1'b0) begin
      n_err++;
      $display("FAIL lat2_result: pass=%b err=%0d fa=%0d fd=%h busy=%b, required 1 0 0 00 0",
               pass2, err2, faddr2, fdata2, busy2);
    end
  endtask

  task automatic test_random();
    int pe, rp, bad;
    logic [4:0] pa; logic [7:0] pd;
    for (int it = 0; it < 6; it++) begin
      fkind = int'($urandom_range(0, 2));
      fa    = 5'($urandom_range(0, DEPTH - 1));
      fb    = int'($urandom_range(0, 7));
      fv    = 1'($urandom_range(0, 1));
      rp    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 190)) : 0;
      predict(pe, pa, pd);
      run_march(rp);
      n_cmp++;
      if (run_cycles != 194) begin
        n_err++; $display("FAIL rand%0d_latency: got %0d, required 194", it, run_cycles);
      end
      n_cmp++;
      if (err1 !== 8'(pe) || faddr1 !== pa || fdata1 !== pd || pass1 !== (pe == 0)) begin
        n_err++;
        $display("FAIL rand%0d_result (kind=%0d a=%0d b=%0d v=%b): err=%0d fa=%0d fd=%h pass=%b, required %0d %0d %h %b",
                 it, fkind, fa, fb, fv, err1, faddr1, fdata1, pass1, pe, pa, pd, (pe == 0));
      end
      bad = 0;
      for (int i = 0; i < NOPS; i++)
        if (tr_wen[i] !== op_we[i] || tr_a[i] !== op_a[i] || tr_d[i] !== op_d[i]) bad++;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL rand%0d_bus: %0d bad cycles, required 0", it, bad); end
    end
    fkind = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; START = 1'b1; START2 = 1'b1;
    build_ops();
    test_reset();
    test_clean_run();
    test_stuck_at();
    test_alias();
    test_repulse();
    test_reset_abort();
    test_read_lat2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
